coriolis_fpmul_share_ctrl: RTL

Time-multiplexes one pipelined FloPoCo FP multiplier (34-bit: 2-bit exception field + IEEE single) between NREQ streaming requesters in the coriolis kernel.
Arbitrates issue round-robin and carries a requester tag down a shadow pipeline matched to the multiplier latency. Routes each result back to its owner and generates the multiplier's stall from downstream back-pressure.
Sits between the kernel's leaf map nodes and a single FPMult_8_23_8_23_8_23 instance.

---
 rtl/coriolis_fp_pkg.sv | 33 +++
 rtl/coriolis_rr_arbiter.sv | 53 +++++
 rtl/coriolis_fpmul_share_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/coriolis_fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : coriolis_fp_pkg
//  Purpose  : Shared constants, types and helpers for the coriolis FloPoCo
//             floating-point datapath blocks.
//  Revision : 1.0  initial release
// ============================================================================
package coriolis_fp_pkg;

  // FloPoCo exception field: 00 zero, 01 normal, 10 infinity, 11 NaN
  localparam logic [1:0] FPC_EF_NORMAL = 2'b01;

  // Pipeline depth of the FPMult_8_23_8_23_8_23 instance in this kernel
  localparam int FPMUL_LAT = 3;

  // Operand width: 2-bit exception field followed by an IEEE single
  localparam int STREAMW_DEFAULT = 34;

  // Field view of a FloPoCo single-precision word
  typedef struct packed {
    logic [1:0]  exc;
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fpc_word_t;

  // Tag width able to name n requesters; never narrower than one bit
  function automatic int tag_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : coriolis_fp_pkg
`default_nettype wire

// File: rtl/coriolis_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : coriolis_rr_arbiter
//  Purpose  : Round-robin arbiter. Searches from the pointer upward (mod NREQ)
//             and grants the first active request; the pointer then moves
//             just past the winner. Holds everything when en is low.
//  Revision : 1.0  initial release
// ============================================================================
module coriolis_rr_arbiter
  import coriolis_fp_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TAGW = tag_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [TAGW-1:0] grant_idx,
  output logic            any
);

  logic [TAGW-1:0] r_ptr;

  // Priority search starting at the pointer; with no winner the index
  // reports the pointer so the operand mux has a defined select.
  always_comb begin
    grant     = '0;
    grant_idx = r_ptr;
    any       = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (en && !any && req[i] && (i == ((int'(r_ptr) + k) % NREQ))) begin
          any       = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = TAGW'(i);
        end
      end
    end
  end

  // Pointer advances to the requester after the winner; holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (any) begin
      r_ptr <= (grant_idx == TAGW'(NREQ - 1)) ? '0 : grant_idx + TAGW'(1);
    end
  end

endmodule : coriolis_rr_arbiter
`default_nettype wire

// File: rtl/coriolis_fpmul_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : coriolis_fpmul_share_ctrl
//  Purpose  : Shares one pipelined FloPoCo multiplier among NREQ streaming
//             requesters. Issues round-robin, tracks ownership in a shadow
//             pipeline matching the multiplier depth, routes results back
//             and freezes the multiplier when the head owner is not ready.
//  Revision : 1.0  initial release
// ============================================================================
module coriolis_fpmul_share_ctrl
  import coriolis_fp_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int STREAMW = STREAMW_DEFAULT,
  parameter int LAT     = FPMUL_LAT,
  parameter int TAGW    = tag_width(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*STREAMW-1:0] req_x,
  input  logic [NREQ*STREAMW-1:0] req_y,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [STREAMW-1:0]      resp_data,
  output logic [STREAMW-1:0]      mul_x,
  output logic [STREAMW-1:0]      mul_y,
  output logic                    mul_stall,
  input  logic [STREAMW-1:0]      mul_r,
  output logic                    busy,
  output logic [15:0]             issue_cnt
);

  // Shadow pipeline: one {valid, owner tag} per multiplier stage
  logic            r_v   [LAT];
  logic [TAGW-1:0] r_tag [LAT];
  logic [15:0]     r_issue_cnt;

  logic            w_head_v;
  logic [TAGW-1:0] w_head_tag;
  logic            w_head_rdy;
  logic            w_stall;
  logic            w_arb_en;
  logic [NREQ-1:0] w_grant;
  logic [TAGW-1:0] w_grant_idx;
  logic            w_grant_any;

  assign w_head_v   = r_v[LAT-1];
  assign w_head_tag = r_tag[LAT-1];

  // Ready of the requester that owns the head result
  always_comb begin
    w_head_rdy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_head_tag == TAGW'(i)) begin
        w_head_rdy = resp_ready[i];
      end
    end
  end

  // Freeze the whole pipe when a valid head cannot be delivered. No issue
  // is allowed while reset is asserted so req_ready reads zero at once.
  assign w_stall  = w_head_v & ~w_head_rdy;
  assign w_arb_en = ~w_stall & ~rst;

  coriolis_rr_arbiter #(
    .NREQ (NREQ),
    .TAGW (TAGW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (w_arb_en),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any       (w_grant_any)
  );

  // Steer the selected requester's operands to the multiplier
  always_comb begin
    mul_x = req_x[STREAMW-1:0];
    mul_y = req_y[STREAMW-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == TAGW'(i)) begin
        mul_x = req_x[i*STREAMW +: STREAMW];
        mul_y = req_y[i*STREAMW +: STREAMW];
      end
    end
  end

  // Advance the shadow pipe in lockstep with the multiplier enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        r_v[s]   <= 1'b0;
        r_tag[s] <= '0;
      end
    end else if (!w_stall) begin
      r_v[0]   <= w_grant_any;
      r_tag[0] <= w_grant_idx;
      for (int s = 1; s < LAT; s++) begin
        r_v[s]   <= r_v[s-1];
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  // Count accepted transfers, wrapping naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_cnt <= '0;
    end else if (w_grant_any) begin
      r_issue_cnt <= r_issue_cnt + 16'd1;
    end
  end

  // Decode the head owner into a one-hot result valid
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid[i] = w_head_v && (w_head_tag == TAGW'(i));
    end
  end

  // Busy whenever any stage carries a live operation
  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < LAT; s++) begin
      busy = busy | r_v[s];
    end
  end

  assign req_ready = w_grant;
  assign mul_stall = w_stall;
  assign resp_data = mul_r;
  assign issue_cnt = r_issue_cnt;

endmodule : coriolis_fpmul_share_ctrl
`default_nettype wire
